// File: rtl/audio_adc_capture.sv
// I2S ADC capture: synchronizes the codec serial interface, deserializes stereo
// words and queues {left,right} pairs in a first-word-fall-through FIFO.
module audio_adc_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrck,
    input  logic                          aud_adcdat,
    input  logic                          sample_ready,
    input  logic                          clear_flags,
    output logic                          sample_valid,
    output logic [DATA_WIDTH-1:0]         sample_left,
    output logic [DATA_WIDTH-1:0]         sample_right,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          frame_err
);

    // state | meaning
    // IDLE  | capture disabled
    // ALIGN | waiting for an LRCK falling edge (start of a left word)
    // SKIP  | edge seen; next BCLK rise carries the MSB
    // SHIFT | shifting in the remaining bits of the word
    // WAIT  | word complete; ignoring bits until the next LRCK edge
    typedef enum logic [2:0] {IDLE, ALIGN, SKIP, SHIFT, WAIT} state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [1:0]              bclk_sync, lrck_sync, dat_sync;
    logic                    bclk_prev, lrck_prev;
    logic                    bclk_rise, lrck_edge, lrck_fall, dat_bit;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg, hold_left, word;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    is_right, held_valid, push_req;
    logic [2*DATA_WIDTH-1:0] push_data;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic                    full, pop, do_push;

    assign dat_bit   = dat_sync[1];
    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrck_edge = bclk_rise & (lrck_sync[1] != lrck_prev);
    assign lrck_fall = lrck_edge & ~lrck_sync[1];
    assign word      = {shift_reg[DATA_WIDTH-2:0], dat_bit};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], aud_bclk};
            lrck_sync <= {lrck_sync[0], aud_adclrck};
            dat_sync  <= {dat_sync[0], aud_adcdat};
            bclk_prev <= bclk_sync[1];
            if (bclk_rise)
                lrck_prev <= lrck_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            is_right   <= 1'b0;
            held_valid <= 1'b0;
            hold_left  <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            // Clear first so that a framing error in the same cycle takes priority.
            if (clear_flags)
                frame_err <= 1'b0;
            if (!enable) begin
                state      <= IDLE;
                held_valid <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: state <= ALIGN;
                    ALIGN: begin
                        if (lrck_fall) begin
                            state      <= SKIP;
                            is_right   <= 1'b0;
                            held_valid <= 1'b0;
                        end
                    end
                    SKIP: begin
                        if (bclk_rise) begin
                            shift_reg <= word;
                            bit_cnt   <= CNT_W'(1);
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (lrck_edge) begin
                            frame_err  <= 1'b1;
                            held_valid <= 1'b0;
                            is_right   <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= lrck_sync[1] ? ALIGN : SKIP;
                        end else if (bclk_rise) begin
                            shift_reg <= word;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                state <= WAIT;
                                if (!is_right) begin
                                    hold_left  <= word;
                                    held_valid <= 1'b1;
                                end else if (held_valid) begin
                                    push_req   <= 1'b1;
                                    push_data  <= {hold_left, word};
                                    held_valid <= 1'b0;
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (lrck_edge) begin
                            state    <= SKIP;
                            is_right <= lrck_sync[1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sample_valid = (level != '0);
    assign full         = (level == LVL_W'(FIFO_DEPTH));
    assign pop          = sample_valid & sample_ready;
    assign do_push      = push_req & (~full | pop);
    assign sample_left  = sample_valid ? mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign sample_right = sample_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset_n && do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (do_push && !pop)
                level <= level + LVL_W'(1);
            else if (!do_push && pop)
                level <= level - LVL_W'(1);
            if (clear_flags)
                overflow <= 1'b0;
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule
